// File: rtl/fa_serial_addsub.sv
// Multi-cycle adder/subtractor: a DIGIT-bit ripple slice with a registered
// carry. It processes the operands LSB-first, DIGIT bits per cycle, and reports
// sum, carry/borrow and signed overflow with a one-cycle done pulse.
module fa_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NCYC = WIDTH / DIGIT;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic [WIDTH-1:0] res_shift;

  // DIGIT-bit ripple slice over the low bits of A/B; c[DIGIT-1] is the carry
  // into the top bit of this digit, which is the operand MSB on the last cycle.
  always_comb begin
    c    = '0;
    dsum = '0;
    c[0] = carry_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1]   = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // Result register fills from the MSB side so that after NCYC digits the
  // first digit has reached bit 0; the shift form also covers WIDTH == DIGIT.
  always_comb begin
    res_shift = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = mode ? ~b : b;
          carry_d = ci ^ mode;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NCYC - 1)) begin
          state_d = DONE;
          s_d     = res_shift;
          co_d    = c[DIGIT] ^ mode_q;
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous active-low reset clears all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_fa_serial_addsub.sv
// Scoreboard bench for fa_serial_addsub with three configurations:
// WIDTH=1/DIGIT=1, WIDTH=8/DIGIT=1 and WIDTH=8/DIGIT=4.
module tb_fa_serial_addsub;

  localparam int WI [3] = '{1, 8, 8};
  localparam int NI [3] = '{1, 8, 2};

  typedef struct {
    int         inst;
    logic [7:0] s;
    logic       co;
    logic       ovf;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic       mode_in, ci_in;
  logic [7:0] a_in, b_in;

  logic       busy0, done0, s0, co0, ovf0;
  logic       busy1, done1, co1, ovf1;
  logic [7:0] s1;
  logic       busy2, done2, co2, ovf2;
  logic [7:0] s2;

  logic [7:0] s_a    [3];
  logic       busy_a [3];
  logic       done_a [3];
  logic       co_a   [3];
  logic       ovf_a  [3];

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt [3] = '{0, 0, 0};
  int   busy_run [3] = '{0, 0, 0};
  logic done_prev [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fa_serial_addsub #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_in),
    .a(a_in[0:0]), .b(b_in[0:0]), .ci(ci_in),
    .busy(busy0), .done(done0), .s(s0), .co(co0), .ovf(ovf0));

  fa_serial_addsub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_in),
    .a(a_in), .b(b_in), .ci(ci_in),
    .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1));

  fa_serial_addsub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_in),
    .a(a_in), .b(b_in), .ci(ci_in),
    .busy(busy2), .done(done2), .s(s2), .co(co2), .ovf(ovf2));

  assign s_a[0]    = {7'b0, s0};
  assign s_a[1]    = s1;
  assign s_a[2]    = s2;
  assign busy_a[0] = busy0;
  assign busy_a[1] = busy1;
  assign busy_a[2] = busy2;
  assign done_a[0] = done0;
  assign done_a[1] = done1;
  assign done_a[2] = done2;
  assign co_a[0]   = co0;
  assign co_a[1]   = co1;
  assign co_a[2]   = co2;
  assign ovf_a[0]  = ovf0;
  assign ovf_a[1]  = ovf1;
  assign ovf_a[2]  = ovf2;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w, input bit m, input int av,
                                 input int bv, input int c);
    exp_t e;
    int full, half, r, sa, sb, sr;
    full  = 1 << w;
    half  = full / 2;
    r     = m ? (av - bv - c) : (av + bv + c);
    e.s   = 8'(r & (full - 1));
    e.co  = m ? (av < bv + c) : (r >= full);
    sa    = (av >= half) ? av - full : av;
    sb    = (bv >= half) ? bv - full : bv;
    sr    = m ? (sa - sb - c) : (sa + sb + c);
    e.ovf = (sr >= half) || (sr < -half);
    e.inst = 0;
    e.due  = -1;
    return e;
  endfunction

  // Monitor: pops the oldest expectation for an instance whenever it pulses done.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_a[i]) busy_run[i]++;
      else           busy_run[i] = 0;
      if (done_a[i]) begin
        int   idx;
        exp_t e;
        done_cnt[i]++;
        chk($sformatf("u%0d_done_width", i), int'(done_prev[i]), 0);
        idx = -1;
        for (int j = 0; j < sbq.size(); j++)
          if (idx < 0 && sbq[j].inst == i) idx = j;
        chk($sformatf("u%0d_done_expected", i), (idx >= 0) ? 1 : 0, 1);
        if (idx >= 0) begin
          e = sbq[idx];
          sbq.delete(idx);
          chk($sformatf("u%0d_s", i), int'(s_a[i]), int'(e.s));
          chk($sformatf("u%0d_co", i), int'(co_a[i]), int'(e.co));
          chk($sformatf("u%0d_ovf", i), int'(ovf_a[i]), int'(e.ovf));
          chk($sformatf("u%0d_busy_cycles", i), busy_run[i], NI[i] + 1);
          if (e.due >= 0) chk($sformatf("u%0d_done_latency", i), cyc, e.due);
        end
      end
      done_prev[i] = done_a[i];
    end
  end

  // One operation: start for a single edge, then wait until the unit is idle.
  task automatic issue(input int inst, input bit m, input logic [7:0] av,
                       input logic [7:0] bv, input bit c);
    exp_t e;
    int   msk;
    msk = (1 << WI[inst]) - 1;
    a_in = av; b_in = bv; mode_in = m; ci_in = c;
    start_v[inst] = 1'b1;
    e = model(WI[inst], m, int'(av) & msk, int'(bv) & msk, int'(c));
    e.inst = inst;
    e.due  = cyc + 1 + NI[inst];
    sbq.push_back(e);
    @(negedge clk);
    start_v[inst] = 1'b0;
    repeat (NI[inst] + 1) @(negedge clk);
  endtask

  logic [7:0] da [6] = '{8'h3C, 8'hFF, 8'h7F, 8'h10, 8'h80, 8'h05};
  logic [7:0] db [6] = '{8'h42, 8'h01, 8'h01, 8'h20, 8'h01, 8'h05};
  logic       dm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       dc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int   base, wait_cnt;
    exp_t e;
    rst_n = 1'b0; start_v = '0; mode_in = 1'b0; ci_in = 1'b0;
    a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_s", int'(s1), 0);
    chk("rst_co", int'(co1), 0);
    chk("rst_ovf", int'(ovf1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-adder truth table on the single-bit unit.
    for (int k = 0; k < 8; k++)
      issue(0, 1'b0, {7'b0, k[1]}, {7'b0, k[0]}, k[2]);

    // Directed add/sub vectors on both 8-bit configurations.
    for (int inst = 1; inst < 3; inst++)
      for (int j = 0; j < 6; j++)
        issue(inst, dm[j], da[j], db[j], dc[j]);

    // Random operations on all three configurations.
    for (int inst = 0; inst < 3; inst++)
      repeat (25)
        issue(inst, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    // start held high; operands disturbed while the first operation runs.
    a_in = 8'h5A; b_in = 8'h33; mode_in = 1'b1; ci_in = 1'b0;
    base = done_cnt[1];
    e = model(8, 1'b1, 'h5A, 'h33, 0);
    e.inst = 1;
    e.due  = cyc + 1 + NI[1];
    sbq.push_back(e);
    e.due = -1;
    sbq.push_back(e);
    sbq.push_back(e);
    start_v[1] = 1'b1;
    repeat (3) @(negedge clk);
    a_in = 8'hFF; b_in = 8'h00; mode_in = 1'b0; ci_in = 1'b1;
    repeat (3) @(negedge clk);
    a_in = 8'h5A; b_in = 8'h33; mode_in = 1'b1; ci_in = 1'b0;
    wait_cnt = 0;
    while (done_cnt[1] < base + 3 && wait_cnt < 100) begin
      @(negedge clk); #1;
      wait_cnt++;
    end
    start_v[1] = 1'b0;
    chk("hold_three_done", done_cnt[1] - base, 3);
    repeat (12) @(negedge clk);

    // Reset during the fourth RUN cycle aborts the operation silently.
    a_in = 8'hC3; b_in = 8'h11; mode_in = 1'b0; ci_in = 1'b0;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", int'(busy1), 0);
    chk("abort_s", int'(s1), 0);
    chk("abort_co", int'(co1), 0);
    chk("abort_ovf", int'(ovf1), 0);
    base = done_cnt[1];
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt[1] - base, 0);
    issue(1, 1'b0, 8'h12, 8'h34, 1'b1);
    issue(1, 1'b1, 8'h12, 8'h34, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
